// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared state encoding, default sizes and helpers for the
//               register-load arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREGS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_load_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first request at or above
//               rr_ptr, wrapping at NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = clog2_min1(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [IW-1:0]   win_idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid            = 1'b1;
        win_idx          = cand;
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_load_arbiter.sv
// ============================================================================
// Module      : reg_load_arbiter
// Description : Round-robin arbiter sharing a bank of load-enabled registers
//               between NREQ requesters. Optional macro REG_LOAD_ARB_LOCK_EN
//               adds a per-requester lock input for burst ownership.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = clog2_min1(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef REG_LOAD_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREGS-1:0]      load_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy,
  output logic                  err_addr
);

  localparam int IW = clog2_min1(NREQ);

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   win_oh_q, win_oh_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREGS-1:0]  load_en_q, load_en_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              err_addr_q, err_addr_d;
`ifdef REG_LOAD_ARB_LOCK_EN
  logic              lock_hold_q, lock_hold_d;
`endif

  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .valid      (pick_valid)
  );

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    return IW'((int'(idx) + 1) % NREQ);
  endfunction

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    win_oh_d   = win_oh_q;
    addr_d     = addr_q;
    data_d     = data_q;
    gnt_d      = '0;
    load_en_d  = '0;
    wr_data_d  = wr_data_q;
    err_addr_d = err_addr_q;
`ifdef REG_LOAD_ARB_LOCK_EN
    lock_hold_d = lock_hold_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef REG_LOAD_ARB_LOCK_EN
        // A locked owner that stops requesting hands priority to its neighbour.
        if (lock_hold_q && !req[rr_ptr_q]) begin
          lock_hold_d = 1'b0;
          rr_ptr_d    = ptr_after(rr_ptr_q);
        end
`endif
        if (pick_valid) begin
          win_d    = pick_idx;
          win_oh_d = pick_onehot;
          addr_d   = req_addr[pick_idx*AW +: AW];
          data_d   = req_data[pick_idx*WIDTH +: WIDTH];
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        gnt_d     = win_oh_q;
        wr_data_d = data_q;
        if (32'(addr_q) >= 32'(NREGS)) begin
          err_addr_d = 1'b1;
        end else begin
          for (int r = 0; r < NREGS; r++) begin
            load_en_d[r] = (32'(addr_q) == 32'(r));
          end
        end
        rr_ptr_d = ptr_after(win_q);
`ifdef REG_LOAD_ARB_LOCK_EN
        if (lock[win_q]) begin
          rr_ptr_d    = win_q;
          lock_hold_d = 1'b1;
        end else begin
          lock_hold_d = 1'b0;
        end
`endif
        state_d = ST_RELEASE;
      end

      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_GRANT) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      win_oh_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
      load_en_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      err_addr_q <= 1'b0;
`ifdef REG_LOAD_ARB_LOCK_EN
      lock_hold_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      win_oh_q   <= win_oh_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      load_en_q  <= load_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      err_addr_q <= err_addr_d;
`ifdef REG_LOAD_ARB_LOCK_EN
      lock_hold_q <= lock_hold_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign load_en  = load_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign err_addr = err_addr_q;

endmodule

`default_nettype wire
